isi_gain_expand: RTL

//  Multi-channel, pipelined ISI gain expander: z = (isi_x-1)*gain[ch] + 1 + isi_y.
//  Per-channel gain is runtime-programmable. Handshakes are valid/ready, with overflow/zero handling and event counting.

---
 rtl/isi_gain_pkg.sv | 29 ++
 rtl/isi_gain_expand_if.sv | 29 ++
 rtl/isi_gain_cfg_regs.sv | 36 +++
 rtl/isi_gain_expand.sv | 126 ++++++++++++
 4 files changed

// File: rtl/isi_gain_pkg.sv
// Shared helpers for the ISI gain expander: derived widths and the S2 result classes.
package isi_gain_pkg;

   localparam logic [1:0] CLS_OK   = 2'd0;
   localparam logic [1:0] CLS_COMP = 2'd1;
   localparam logic [1:0] CLS_OVF  = 2'd2;
   localparam logic [1:0] CLS_ZERO = 2'd3;

   function automatic int bit_g(input int g_max);
      return $clog2(g_max + 1);
   endfunction

   function automatic int bit_y(input int g_max);
      return $clog2(g_max);
   endfunction

   function automatic int bit_ch(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   // Zero-x outranks overflow, which outranks the compensation flags.
   function automatic logic [1:0] classify(input logic zx, input logic ovf, input logic comp);
      if (zx)        return CLS_ZERO;
      else if (ovf)  return CLS_OVF;
      else if (comp) return CLS_COMP;
      else           return CLS_OK;
   endfunction

endpackage

// File: rtl/isi_gain_expand_if.sv
// Input/output stream bundle of the ISI gain expander; master drives beats, slave is the expander.
interface isi_gain_expand_if #(
   parameter int BIT_ISI = 8,
   parameter int BIT_CH  = 2,
   parameter int BIT_Y   = 3
);
   logic               in_valid;
   logic               in_ready;
   logic [BIT_CH-1:0]  in_ch;
   logic [BIT_ISI-1:0] isi_x;
   logic [BIT_Y-1:0]   isi_y;
   logic               comp_addr_x;
   logic               comp_addr_y;
   logic               out_valid;
   logic               out_ready;
   logic [BIT_CH-1:0]  out_ch;
   logic [BIT_ISI-1:0] isi_z;
   logic               out_sat;

   modport master (
      output in_valid, in_ch, isi_x, isi_y, comp_addr_x, comp_addr_y, out_ready,
      input  in_ready, out_valid, out_ch, isi_z, out_sat
   );

   modport slave (
      input  in_valid, in_ch, isi_x, isi_y, comp_addr_x, comp_addr_y, out_ready,
      output in_ready, out_valid, out_ch, isi_z, out_sat
   );
endinterface

// File: rtl/isi_gain_cfg_regs.sv
// Per-channel gain register file; resets to G_MAX, ignores writes of 0 or above G_MAX.
module isi_gain_cfg_regs #(
   parameter int G_MAX  = 7,
   parameter int NCH    = 4,
   parameter int BIT_G  = 3,
   parameter int BIT_CH = 2
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              we,
   input  logic [BIT_CH-1:0] wch,
   input  logic [BIT_G-1:0]  wdata,
   input  logic [BIT_CH-1:0] rch,
   output logic [BIT_G-1:0]  rdata
);
   logic [NCH-1:0][BIT_G-1:0] gain;
   logic                      wdata_ok;

   assign wdata_ok = (wdata != '0) && ({1'b0, wdata} <= (BIT_G+1)'(G_MAX));

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         gain <= {NCH{BIT_G'(G_MAX)}};
      end else if (we && wdata_ok) begin
         for (int i = 0; i < NCH; i++)
            if (wch == BIT_CH'(i)) gain[i] <= wdata;
      end
   end

   // Unpopulated channel codes read back as G_MAX.
   always_comb begin
      rdata = BIT_G'(G_MAX);
      for (int i = 0; i < NCH; i++)
         if (rch == BIT_CH'(i)) rdata = gain[i];
   end
endmodule

// File: rtl/isi_gain_expand.sv
// Two-stage multi-channel ISI gain expander z = (x-1)*gain[ch] + 1 + y.
// Define ISI_GAIN_SAT_EN to saturate overflowing results instead of dropping them.
module isi_gain_expand
   import isi_gain_pkg::*;
#(
   parameter int BIT_ISI = 8,
   parameter int G_MAX   = 7,
   parameter int NCH     = 4,
   parameter int CNT_W   = 16,
   localparam int BIT_G  = bit_g(G_MAX),
   localparam int BIT_Y  = bit_y(G_MAX),
   localparam int BIT_CH = bit_ch(NCH)
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              cfg_we,
   input  logic [BIT_CH-1:0] cfg_ch,
   input  logic [BIT_G-1:0]  cfg_gain,
   isi_gain_expand_if.slave  bus,
   output logic [CNT_W-1:0]  evt_cnt
);
   localparam int SW = BIT_ISI + BIT_G + 1;

   typedef struct packed {
      logic [BIT_CH-1:0] ch;
      logic [BIT_Y-1:0]  y;
      logic              comp;
      logic              zx;
      logic [SW-1:0]     p;
   } s1_t;

   s1_t              s1_d, s1_q;
   logic             s1_vld;
   logic [BIT_G-1:0] gain_rd;
   logic             stall;
   logic [SW-1:0]    sum;
   logic             ovf;
   logic [1:0]       cls;

   assign stall       = bus.out_valid & ~bus.out_ready;
   assign bus.in_ready = ~stall;

   isi_gain_cfg_regs #(.G_MAX(G_MAX), .NCH(NCH), .BIT_G(BIT_G), .BIT_CH(BIT_CH)) u_cfg (
      .clk   (clk),
      .clr_n (clr_n),
      .we    (cfg_we),
      .wch   (cfg_ch),
      .wdata (cfg_gain),
      .rch   (bus.in_ch),
      .rdata (gain_rd)
   );

   // Gain is read before this edge's write lands, so a same-cycle write never affects the beat.
   always_comb begin
      s1_d.ch   = bus.in_ch;
      s1_d.y    = bus.isi_y;
      s1_d.comp = bus.comp_addr_x | bus.comp_addr_y;
      s1_d.zx   = (bus.isi_x == '0);
      s1_d.p    = (SW'(bus.isi_x) - SW'(1)) * SW'(gain_rd);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         s1_vld <= 1'b0;
         s1_q   <= '0;
      end else if (!stall) begin
         s1_vld <= bus.in_valid;
         if (bus.in_valid) s1_q <= s1_d;
      end
   end

   assign sum = s1_q.p + SW'(1) + SW'(s1_q.y);
   assign ovf = |sum[SW-1:BIT_ISI];
   assign cls = classify(s1_q.zx, ovf, s1_q.comp);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         bus.out_valid <= 1'b0;
         bus.out_ch    <= '0;
         bus.isi_z     <= '0;
      end else if (!stall) begin
         bus.out_valid <= 1'b0;
         if (s1_vld) begin
            case (cls)
               CLS_OK: begin
                  bus.out_valid <= 1'b1;
                  bus.isi_z     <= sum[BIT_ISI-1:0];
                  bus.out_ch    <= s1_q.ch;
               end
               CLS_COMP: begin
                  bus.isi_z     <= sum[BIT_ISI-1:0];
                  bus.out_ch    <= s1_q.ch;
               end
`ifdef ISI_GAIN_SAT_EN
               CLS_OVF: begin
                  bus.out_valid <= ~s1_q.comp;
                  bus.isi_z     <= '1;
                  bus.out_ch    <= s1_q.ch;
               end
`endif
               default: ;
            endcase
         end
      end
   end

`ifdef ISI_GAIN_SAT_EN
   logic sat_q;
   assign bus.out_sat = sat_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)                               sat_q <= 1'b0;
      else if (!stall && s1_vld && cls == CLS_OK)  sat_q <= 1'b0;
      else if (!stall && s1_vld && cls == CLS_OVF) sat_q <= 1'b1;
   end
`else
   assign bus.out_sat = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n)
         evt_cnt <= '0;
      else if (!stall && s1_vld && (cls == CLS_ZERO || cls == CLS_OVF) && evt_cnt != '1)
         evt_cnt <= evt_cnt + CNT_W'(1);
   end
endmodule
